// File: rtl/rob_commit.sv
// rob_commit: reorder buffer in front of the GPR file.
// Entries are allocated in program order at the tail. Results arrive out of
// order through the writeback port. At most one finished entry retires per
// cycle from the head, which drives the register-file write port. A single
// query port lets dispatch read results that are done but not yet retired.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef GPR_ADDR_WIDTH
`define GPR_ADDR_WIDTH 5
`endif

module rob_commit #(
    parameter int ROB_DEPTH    = 8,
    parameter int ROB_ID_WIDTH = 3,
    parameter int WORD_W       = `WORD_WIDTH,
    parameter int GPR_ADDR_W   = `GPR_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    dispatch_en,
    input  logic                    dispatch_has_dst,
    input  logic [GPR_ADDR_W-1:0]   dispatch_dst_addr,
    output logic                    dispatch_ready,
    output logic [ROB_ID_WIDTH-1:0] dispatch_rob_id,
    input  logic                    wb_en,
    input  logic [ROB_ID_WIDTH-1:0] wb_rob_id,
    input  logic [WORD_W-1:0]       wb_value,
    input  logic [ROB_ID_WIDTH-1:0] query_rob_id,
    output logic                    query_ready,
    output logic [WORD_W-1:0]       query_value,
    output logic                    rob_retire,
    output logic                    commit_en,
    output logic [GPR_ADDR_W-1:0]   rob_commit_dst_addr,
    output logic [WORD_W-1:0]       rob_commit_dst_value,
    output logic                    rob_empty,
    output logic                    rob_full
);

    // Pointers carry one extra wrap bit above the index bits.
    localparam logic [ROB_ID_WIDTH:0] PTR_ONE = {{ROB_ID_WIDTH{1'b0}}, 1'b1};

    logic [ROB_DEPTH-1:0]  valid_q,   valid_d;
    logic [ROB_DEPTH-1:0]  done_q,    done_d;
    logic [ROB_DEPTH-1:0]  has_dst_q, has_dst_d;
    logic [GPR_ADDR_W-1:0] dst_addr_q [ROB_DEPTH];
    logic [GPR_ADDR_W-1:0] dst_addr_d [ROB_DEPTH];
    logic [WORD_W-1:0]     value_q    [ROB_DEPTH];
    logic [WORD_W-1:0]     value_d    [ROB_DEPTH];
    logic [ROB_ID_WIDTH:0] head_q, head_d;
    logic [ROB_ID_WIDTH:0] tail_q, tail_d;

    logic [ROB_ID_WIDTH-1:0] head_idx_s;
    logic [ROB_ID_WIDTH-1:0] tail_idx_s;
    logic                    empty_s;
    logic                    full_s;
    logic                    retire_s;
    logic                    query_hit_s;

    assign head_idx_s = head_q[ROB_ID_WIDTH-1:0];
    assign tail_idx_s = tail_q[ROB_ID_WIDTH-1:0];
    assign empty_s    = (head_q == tail_q);
    assign full_s     = (head_idx_s == tail_idx_s) &&
                        (head_q[ROB_ID_WIDTH] != tail_q[ROB_ID_WIDTH]);

    // Retirement is a zero-latency view of the registered head; a flush
    // cycle suppresses it so nothing is written to the GPR file.
    assign retire_s    = !flush && valid_q[head_idx_s] && done_q[head_idx_s];
    assign query_hit_s = valid_q[query_rob_id] && done_q[query_rob_id];

    assign dispatch_ready       = !full_s;
    assign dispatch_rob_id      = tail_idx_s;
    assign rob_empty            = empty_s;
    assign rob_full             = full_s;
    assign rob_retire           = retire_s;
    assign commit_en            = retire_s && has_dst_q[head_idx_s] &&
                                  (dst_addr_q[head_idx_s] != {GPR_ADDR_W{1'b0}});
    assign rob_commit_dst_addr  = retire_s ? dst_addr_q[head_idx_s] : {GPR_ADDR_W{1'b0}};
    assign rob_commit_dst_value = retire_s ? value_q[head_idx_s] : {WORD_W{1'b0}};
    assign query_ready          = query_hit_s;
    assign query_value          = query_hit_s ? value_q[query_rob_id] : {WORD_W{1'b0}};

    // Next-state: flush wins; otherwise retire, writeback and dispatch all apply.
    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        has_dst_d  = has_dst_q;
        dst_addr_d = dst_addr_q;
        value_d    = value_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (flush) begin
            valid_d = {ROB_DEPTH{1'b0}};
            done_d  = {ROB_DEPTH{1'b0}};
            head_d  = {(ROB_ID_WIDTH+1){1'b0}};
            tail_d  = {(ROB_ID_WIDTH+1){1'b0}};
        end else begin
            if (retire_s) begin
                valid_d[head_idx_s] = 1'b0;
                head_d              = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            // Writeback only lands on a live entry; a repeat overwrites the value.
            if (wb_en && valid_q[wb_rob_id]) begin
                done_d[wb_rob_id]  = 1'b1;
                value_d[wb_rob_id] = wb_value;
            end else begin
                done_d = done_d;
            end
            // Fullness is judged on registered state only, so a retire in the
            // same cycle does not open a slot for this dispatch.
            if (dispatch_en && !full_s) begin
                valid_d[tail_idx_s]    = 1'b1;
                done_d[tail_idx_s]     = 1'b0;
                has_dst_d[tail_idx_s]  = dispatch_has_dst;
                dst_addr_d[tail_idx_s] = dispatch_dst_addr;
                tail_d                 = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= {ROB_DEPTH{1'b0}};
            done_q    <= {ROB_DEPTH{1'b0}};
            has_dst_q <= {ROB_DEPTH{1'b0}};
            head_q    <= {(ROB_ID_WIDTH+1){1'b0}};
            tail_q    <= {(ROB_ID_WIDTH+1){1'b0}};
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dst_addr_q[i] <= {GPR_ADDR_W{1'b0}};
                value_q[i]    <= {WORD_W{1'b0}};
            end
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            has_dst_q  <= has_dst_d;
            dst_addr_q <= dst_addr_d;
            value_q    <= value_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit. Stimulus pushes the expected retirement
// tuples (commit_en, addr, value) into a scoreboard queue in program order;
// a monitor pops and compares whenever the DUT reports rob_retire.

module tb_rob_commit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dispatch_en;
    logic        dispatch_has_dst;
    logic [4:0]  dispatch_dst_addr;
    logic        dispatch_ready;
    logic [2:0]  dispatch_rob_id;
    logic        wb_en;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic [2:0]  query_rob_id;
    logic        query_ready;
    logic [31:0] query_value;
    logic        rob_retire;
    logic        commit_en;
    logic [4:0]  rob_commit_dst_addr;
    logic [31:0] rob_commit_dst_value;
    logic        rob_empty;
    logic        rob_full;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    rob_commit dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush                (flush),
        .dispatch_en          (dispatch_en),
        .dispatch_has_dst     (dispatch_has_dst),
        .dispatch_dst_addr    (dispatch_dst_addr),
        .dispatch_ready       (dispatch_ready),
        .dispatch_rob_id      (dispatch_rob_id),
        .wb_en                (wb_en),
        .wb_rob_id            (wb_rob_id),
        .wb_value             (wb_value),
        .query_rob_id         (query_rob_id),
        .query_ready          (query_ready),
        .query_value          (query_value),
        .rob_retire           (rob_retire),
        .commit_en            (commit_en),
        .rob_commit_dst_addr  (rob_commit_dst_addr),
        .rob_commit_dst_value (rob_commit_dst_value),
        .rob_empty            (rob_empty),
        .rob_full             (rob_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic en, input logic [4:0] addr, input logic [31:0] val);
        exp_t e;
        e.en   = en;
        e.addr = addr;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic disp(input logic has, input logic [4:0] addr);
        dispatch_en       = 1'b1;
        dispatch_has_dst  = has;
        dispatch_dst_addr = addr;
        cyc();
        dispatch_en       = 1'b0;
    endtask

    task automatic wb(input logic [2:0] id, input logic [31:0] val);
        wb_en     = 1'b1;
        wb_rob_id = id;
        wb_value  = val;
        cyc();
        wb_en     = 1'b0;
    endtask

    // Monitor: every retirement must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rob_retire) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("commit_en",    {31'd0, commit_en}, {31'd0, e.en});
                    chk("commit_addr",  {27'd0, rob_commit_dst_addr}, {27'd0, e.addr});
                    chk("commit_value", rob_commit_dst_value, e.val);
                end
            end else if (commit_en) begin
                chk("commit_without_retire", 32'd1, 32'd0);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] id;
        rst_n = 1'b0; flush = 1'b0;
        dispatch_en = 1'b0; dispatch_has_dst = 1'b0; dispatch_dst_addr = 5'd0;
        wb_en = 1'b0; wb_rob_id = 3'd0; wb_value = 32'd0; query_rob_id = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_empty",    {31'd0, rob_empty}, 32'd1);
        chk("rst_full",     {31'd0, rob_full}, 32'd0);
        chk("rst_ready",    {31'd0, dispatch_ready}, 32'd1);
        chk("rst_rob_id",   {29'd0, dispatch_rob_id}, 32'd0);
        chk("rst_commit",   {31'd0, commit_en}, 32'd0);
        chk("rst_retire",   {31'd0, rob_retire}, 32'd0);
        chk("rst_qready",   {31'd0, query_ready}, 32'd0);

        // Out-of-order writeback, in-order commit
        disp(1'b1, 5'd5);
        chk("t1_id_after1", {29'd0, dispatch_rob_id}, 32'd1);
        disp(1'b1, 5'd6);
        push(1'b1, 5'd5, 32'hAA);
        push(1'b1, 5'd6, 32'hBB);
        wb(3'd1, 32'hBB);
        chk("t1_no_retire_younger", {31'd0, rob_retire}, 32'd0);
        wb_en = 1'b1; wb_rob_id = 3'd0; wb_value = 32'hAA;
        #1;
        chk("t1_no_wb_bypass", {31'd0, rob_retire}, 32'd0);
        cyc();
        wb_en = 1'b0;
        chk("t1_retire_next", {31'd0, rob_retire}, 32'd1);
        cyc();
        chk("t1_retire_second", {31'd0, rob_retire}, 32'd1);
        cyc();
        chk("t1_empty", {31'd0, rob_empty}, 32'd1);

        // Fill all 8 entries starting at index 2
        for (int i = 0; i < 8; i++) begin
            disp(1'b1, 5'(8 + i));
            push(1'b1, 5'(8 + i), 32'h100 + 32'(i));
        end
        chk("t2_full",   {31'd0, rob_full}, 32'd1);
        chk("t2_ready",  {31'd0, dispatch_ready}, 32'd0);
        chk("t2_rob_id", {29'd0, dispatch_rob_id}, 32'd2);
        disp(1'b1, 5'd31);
        chk("t2_full_after_drop",  {31'd0, rob_full}, 32'd1);
        chk("t2_rob_id_after_drop", {29'd0, dispatch_rob_id}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            id = 3'(2 + i);
            wb(id, 32'h100 + 32'(i));
            chk("t2_consecutive_retire", {31'd0, rob_retire}, 32'd1);
        end
        cyc();
        chk("t2_drain_empty",  {31'd0, rob_empty}, 32'd1);
        chk("t2_drain_full",   {31'd0, rob_full}, 32'd0);
        chk("t2_drain_rob_id", {29'd0, dispatch_rob_id}, 32'd2);

        // x0 destination and no-destination entries retire without a write
        disp(1'b1, 5'd0);
        disp(1'b0, 5'd7);
        push(1'b0, 5'd0, 32'h55);
        push(1'b0, 5'd7, 32'h66);
        wb(3'd2, 32'h55);
        chk("t3_retire_x0", {31'd0, rob_retire}, 32'd1);
        wb(3'd3, 32'h66);
        chk("t3_retire_nodst", {31'd0, rob_retire}, 32'd1);
        cyc();
        chk("t3_empty", {31'd0, rob_empty}, 32'd1);

        // Flush with a same-cycle writeback to the head
        disp(1'b1, 5'd1);
        disp(1'b1, 5'd2);
        disp(1'b1, 5'd3);
        wb_en = 1'b1; wb_rob_id = 3'd4; wb_value = 32'h77; flush = 1'b1;
        #1;
        chk("t4_flush_retire", {31'd0, rob_retire}, 32'd0);
        chk("t4_flush_commit", {31'd0, commit_en}, 32'd0);
        cyc();
        wb_en = 1'b0; flush = 1'b0;
        chk("t4_empty",  {31'd0, rob_empty}, 32'd1);
        chk("t4_rob_id", {29'd0, dispatch_rob_id}, 32'd0);
        cyc();
        chk("t4_no_late_retire", {31'd0, rob_retire}, 32'd0);
        query_rob_id = 3'd4;
        #1;
        chk("t4_query_cleared", {31'd0, query_ready}, 32'd0);

        // Forwarding query, ignored writeback, overwriting writeback
        disp(1'b1, 5'd9);
        disp(1'b1, 5'd10);
        disp(1'b1, 5'd11);
        wb(3'd5, 32'hDEAD);
        wb(3'd2, 32'h5555);
        wb(3'd2, 32'h1234);
        query_rob_id = 3'd2;
        #1;
        chk("t5_q2_ready", {31'd0, query_ready}, 32'd1);
        chk("t5_q2_value", query_value, 32'h1234);
        query_rob_id = 3'd5;
        #1;
        chk("t5_q5_ready", {31'd0, query_ready}, 32'd0);
        chk("t5_q5_value", query_value, 32'h0);
        query_rob_id = 3'd0;
        #1;
        chk("t5_q0_notdone", {31'd0, query_ready}, 32'd0);
        push(1'b1, 5'd9,  32'h11);
        push(1'b1, 5'd10, 32'h22);
        push(1'b1, 5'd11, 32'h1234);
        wb(3'd0, 32'h11);
        wb(3'd1, 32'h22);
        cyc();
        cyc();
        chk("t5_empty", {31'd0, rob_empty}, 32'd1);
        repeat (3) cyc();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
